// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;
   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;
endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client (master) and seq_divider (slave).
interface seq_divider_if
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem, quo} left, trial subtract.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           ge;

   // rem_in < divisor, so shifted < 2*divisor: a borrow out of the WIDTH+1 bit
   // subtract is exactly "shifted < divisor", and a kept diff always fits WIDTH bits.
   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      ge      = ~diff[WIDTH];
      rem_out = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], ge};
   end
endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: WIDTH restoring steps, one per clock, with divide-by-zero bypass.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   seq_divider_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem_q, rem_nxt;
   logic [WIDTH-1:0] quo_q, quo_nxt;
   logic [WIDTH-1:0] dsr_q;
   logic             dbz_q;
   logic             last_step;

   assign last_step = (cnt == CW'(WIDTH - 1));

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (dsr_q),
      .rem_out (rem_nxt),
      .quo_out (quo_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state)
         IDLE:    if (bus.start) state_n = (bus.divisor != '0) ? COMPUTE : DONE;
         COMPUTE: begin
            bus.busy = 1'b1;
            if (last_step) state_n = DONE;
         end
         DONE:    begin
            bus.done = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // quo_q starts as the dividend and is shifted into the quotient in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dsr_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (bus.start) begin
               cnt   <= '0;
               dsr_q <= bus.divisor;
               dbz_q <= (bus.divisor == '0);
               if (bus.divisor == '0) begin
                  quo_q <= '1;
                  rem_q <= bus.dividend;
               end else begin
                  quo_q <= bus.dividend;
                  rem_q <= '0;
               end
            end
            COMPUTE: begin
               rem_q <= rem_nxt;
               quo_q <= quo_nxt;
               cnt   <= last_step ? '0 : cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed vector table plus corner sequences and a parallel-lane full 8-bit sweep.
module tb_seq_divider;
   localparam int W  = 8;
   localparam int NL = 16;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   sweep_go = 1'b0;
   int   lanes_done = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   seq_divider_if #(.WIDTH(W)) bif ();
   seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

   typedef struct {
      int a;
      int b;
      int q;
      int r;
      int z;
      int lat;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Called at a negedge with the DUT idle; returns one negedge after done.
   task automatic run_op(input int a, input int b, output int q, output int r,
                         output int z, output int lat);
      bif.start    = 1'b1;
      bif.dividend = W'(a);
      bif.divisor  = W'(b);
      @(negedge clk);
      bif.start = 1'b0;
      lat = 0;
      while (!bif.done && lat < W + 4) begin
         @(negedge clk);
         lat++;
      end
      if (!bif.done) lat = -1;
      q = bif.quotient;
      r = bif.remainder;
      z = bif.div_by_zero;
      @(negedge clk);
   endtask

   vec_t vt[9];

   initial begin
      int q, r, z, lat;
      int guard;
      vt[0] = '{100, 7,   14,  2,  0, 8};
      vt[1] = '{255, 1,   255, 0,  0, 8};
      vt[2] = '{5,   200, 0,   5,  0, 8};
      vt[3] = '{42,  0,   255, 42, 1, 0};
      vt[4] = '{9,   3,   3,   0,  0, 8};
      vt[5] = '{0,   5,   0,   0,  0, 8};
      vt[6] = '{255, 255, 1,   0,  0, 8};
      vt[7] = '{254, 255, 0,   254,0, 8};
      vt[8] = '{0,   0,   255, 0,  1, 0};

      bif.start = 1'b0; bif.dividend = '0; bif.divisor = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_busy", bif.busy, 0);
      chk("reset_done", bif.done, 0);
      chk("reset_quotient", bif.quotient, 0);
      chk("reset_remainder", bif.remainder, 0);
      chk("reset_dbz", bif.div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_op(vt[i].a, vt[i].b, q, r, z, lat);
         chk($sformatf("v%0d_quotient", i), q, vt[i].q);
         chk($sformatf("v%0d_remainder", i), r, vt[i].r);
         chk($sformatf("v%0d_dbz", i), z, vt[i].z);
         chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
         chk($sformatf("v%0d_done_width", i), bif.done, 0);
      end

      // Results hold in IDLE while operands wiggle without start.
      run_op(100, 7, q, r, z, lat);
      for (int i = 0; i < 3; i++) begin
         bif.dividend = W'(17 * i + 3);
         bif.divisor  = W'(i);
         @(negedge clk);
      end
      chk("hold_quotient", bif.quotient, 14);
      chk("hold_remainder", bif.remainder, 2);
      chk("hold_busy", bif.busy, 0);

      // start pulses during COMPUTE and DONE are ignored.
      bif.start = 1'b1; bif.dividend = 8'd100; bif.divisor = 8'd7;
      @(negedge clk);
      bif.start = 1'b0;
      lat = 0;
      while (!bif.done && lat < W + 4) begin
         bif.start    = (lat == 2 || lat == 5);
         bif.dividend = 8'd50;
         bif.divisor  = 8'd5;
         @(negedge clk);
         lat++;
      end
      if (!bif.done) lat = -1;
      chk("ign_latency", lat, 8);
      chk("ign_quotient", bif.quotient, 14);
      chk("ign_remainder", bif.remainder, 2);
      bif.start = 1'b1;
      @(negedge clk);
      bif.start = 1'b0;
      chk("ign_done_start_busy", bif.busy, 0);
      chk("ign_done_start_done", bif.done, 0);
      chk("ign_done_start_quotient", bif.quotient, 14);
      @(negedge clk);

      // Reset partway through 200/3 aborts with no done pulse.
      bif.start = 1'b1; bif.dividend = 8'd200; bif.divisor = 8'd3;
      @(negedge clk);
      bif.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", bif.busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", bif.busy, 0);
      chk("abort_done", bif.done, 0);
      chk("abort_quotient", bif.quotient, 0);
      chk("abort_remainder", bif.remainder, 0);
      chk("abort_dbz", bif.div_by_zero, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bif.done || bif.busy) seen++;
         end
         chk("abort_no_done", seen, 0);
      end
      run_op(200, 3, q, r, z, lat);
      chk("post_abort_quotient", q, 66);
      chk("post_abort_remainder", r, 2);
      chk("post_abort_dbz", z, 0);
      chk("post_abort_latency", lat, 8);

      sweep_go = 1'b1;
      guard = 0;
      while (lanes_done < NL && guard < 80000) begin
         @(negedge clk);
         guard++;
      end
      chk("sweep_lanes_finished", lanes_done, NL);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Each lane sweeps the divisors congruent to its index, all dividends.
   for (genvar l = 0; l < NL; l++) begin : g_lane
      seq_divider_if #(.WIDTH(W)) lif ();
      seq_divider #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(lif.slave));

      initial begin
         int lat, eq, er, ez, el, prints;
         bit ok;
         prints = 0;
         lif.start = 1'b0; lif.dividend = '0; lif.divisor = '0;
         wait (sweep_go);
         @(negedge clk);
         for (int d = l; d < 256; d += NL) begin
            for (int n = 0; n < 256; n++) begin
               lif.start = 1'b1;
               lif.dividend = n[7:0];
               lif.divisor  = d[7:0];
               @(negedge clk);
               lif.start = 1'b0;
               lat = 0;
               while (!lif.done && lat < W + 4) begin
                  @(negedge clk);
                  lat++;
               end
               if (!lif.done) lat = -1;
               eq = (d == 0) ? 255 : n / d;
               er = (d == 0) ? n : n % d;
               ez = (d == 0) ? 1 : 0;
               el = (d == 0) ? 0 : W;
               ok = (int'(lif.quotient) == eq) && (int'(lif.remainder) == er) &&
                    (int'(lif.div_by_zero) == ez) && (lat == el);
               if (d != 0)
                  ok = ok && (int'(lif.quotient) * d + int'(lif.remainder) == n) &&
                       (int'(lif.remainder) < d);
               n_checks++;
               if (ok) n_pass++;
               else if (prints < 8) begin
                  prints++;
                  $display("FAIL sweep %0d/%0d: got q=%0d r=%0d z=%0d lat=%0d expected q=%0d r=%0d z=%0d lat=%0d",
                           n, d, lif.quotient, lif.remainder, lif.div_by_zero, lat, eq, er, ez, el);
               end
               @(negedge clk);
            end
         end
         lanes_done++;
      end
   end
endmodule
